// File: rtl/alu_sequencer.sv
// Command sequencer for an external combinational ALU: holds A/B operands and flags,
// and steps single-bit shifts over several cycles.
module alu_sequencer #(
   parameter int DATA_BITS = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [2:0]           cmd_op,
   input  logic [DATA_BITS-1:0] cmd_data,
   output logic [DATA_BITS-1:0] alu_a,
   output logic [DATA_BITS-1:0] alu_b,
   output logic [1:0]           alu_op,
   input  logic [DATA_BITS-1:0] alu_result,
   input  logic                 alu_carry,
   input  logic                 alu_zero,
   output logic                 carry_flag,
   output logic                 zero_flag,
   output logic                 out_valid,
   output logic [DATA_BITS-1:0] out_data
);

   typedef enum logic [1:0] {IDLE, EXEC, SHIFT} state_t;

   localparam logic [2:0] OP_LDA = 3'b000;
   localparam logic [2:0] OP_LDB = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;
   localparam logic [2:0] OP_SHL = 3'b100;
   localparam logic [2:0] OP_SHR = 3'b101;
   localparam logic [2:0] OP_OUT = 3'b110;

   state_t               state, state_nxt;
   logic [DATA_BITS-1:0] a_reg, b_reg;
   logic [2:0]           cnt;
   logic [1:0]           op_reg;
   logic                 accept;
   logic                 shift_nz;

   assign accept   = cmd_valid && cmd_ready;
   assign shift_nz = (cmd_data[2:0] != 3'd0);
   assign alu_a    = a_reg;
   assign alu_b    = b_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept) begin
               if (cmd_op == OP_ADD || cmd_op == OP_SUB)
                  state_nxt = EXEC;
               else if ((cmd_op == OP_SHL || cmd_op == OP_SHR) && shift_nz)
                  state_nxt = SHIFT;
            end
         end
         EXEC:    state_nxt = IDLE;
         SHIFT:   if (cnt == 3'd1) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // The ALU sees add in IDLE; the latched op only matters while busy.
   always_comb begin
      cmd_ready = (state == IDLE);
      alu_op    = (state == IDLE) ? 2'b00 : op_reg;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_reg      <= '0;
         b_reg      <= '0;
         cnt        <= 3'd0;
         op_reg     <= 2'b00;
         carry_flag <= 1'b0;
         zero_flag  <= 1'b0;
         out_valid  <= 1'b0;
         out_data   <= '0;
      end else begin
         out_valid <= accept && (cmd_op == OP_OUT);
         case (state)
            IDLE: begin
               if (accept) begin
                  case (cmd_op)
                     OP_LDA: a_reg  <= cmd_data;
                     OP_LDB: b_reg  <= cmd_data;
                     OP_ADD: op_reg <= 2'b00;
                     OP_SUB: op_reg <= 2'b01;
                     OP_SHL: if (shift_nz) begin
                        op_reg <= 2'b10;
                        cnt    <= cmd_data[2:0];
                     end
                     OP_SHR: if (shift_nz) begin
                        op_reg <= 2'b11;
                        cnt    <= cmd_data[2:0];
                     end
                     OP_OUT: out_data <= a_reg;
                     default: ;
                  endcase
               end
            end
            EXEC: begin
               a_reg      <= alu_result;
               carry_flag <= alu_carry;
               zero_flag  <= alu_zero;
            end
            SHIFT: begin
               a_reg      <= alu_result;
               carry_flag <= alu_carry;
               zero_flag  <= alu_zero;
               cnt        <= cnt - 3'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural single-bit-shift ALU attached.
module tb_alu_sequencer;

   localparam int W = 8;
   localparam logic [2:0] LDA = 3'b000, LDB = 3'b001, ADD = 3'b010, SUB = 3'b011;
   localparam logic [2:0] SHL = 3'b100, SHR = 3'b101, OUT = 3'b110, NOP = 3'b111;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         cmd_valid = 1'b0;
   logic         cmd_ready;
   logic [2:0]   cmd_op = NOP;
   logic [W-1:0] cmd_data = '0;
   logic [W-1:0] alu_a, alu_b, alu_result, out_data;
   logic [1:0]   alu_op;
   logic         alu_carry, alu_zero, carry_flag, zero_flag, out_valid;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   alu_sequencer #(.DATA_BITS(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
      .carry_flag(carry_flag), .zero_flag(zero_flag),
      .out_valid(out_valid), .out_data(out_data)
   );

   // External ALU: shifts move one bit per step; carry is the bit shifted out / borrow.
   always_comb begin
      logic [W:0] sum;
      sum        = '0;
      alu_result = '0;
      alu_carry  = 1'b0;
      case (alu_op)
         2'b00: begin sum = {1'b0, alu_a} + {1'b0, alu_b}; alu_result = sum[W-1:0]; alu_carry = sum[W]; end
         2'b01: begin alu_result = alu_a - alu_b; alu_carry = (alu_a < alu_b); end
         2'b10: begin alu_result = alu_a << 1; alu_carry = alu_a[W-1]; end
         default: begin alu_result = alu_a >> 1; alu_carry = alu_a[0]; end
      endcase
      alu_zero = (alu_result == '0);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Present a command for one edge; returns 1 ns after that edge.
   task automatic issue(input logic [2:0] op, input logic [W-1:0] data);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = data;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      cmd_op    = NOP;
   endtask

   // Counts edges until cmd_ready returns, bounded.
   task automatic wait_idle(output int busy);
      busy = 0;
      while (!cmd_ready && busy < 20) begin
         @(posedge clk); #1;
         busy++;
      end
   endtask

   int busy;

   initial begin
      // Reset values, and a command offered during reset must be ignored
      cmd_valid = 1'b1; cmd_op = LDA; cmd_data = 8'h77;
      @(posedge clk); #1;
      chk("rst_a", alu_a, 8'h00);
      chk("rst_b", alu_b, 8'h00);
      chk("rst_op", alu_op, 2'b00);
      chk("rst_flags", {carry_flag, zero_flag}, 2'b00);
      chk("rst_out", {out_valid, out_data}, 9'h000);
      cmd_valid = 1'b0; cmd_op = NOP;
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_ready", cmd_ready, 1'b1);

      // ADD with carry out
      issue(LDA, 8'hF0);
      issue(LDB, 8'h20);
      chk("ldb_b", alu_b, 8'h20);
      issue(ADD, 8'h00);
      chk("add_op", alu_op, 2'b00);
      wait_idle(busy);
      chk("add_busy", busy, 1);
      chk("add_a", alu_a, 8'h10);
      chk("add_flags", {carry_flag, zero_flag}, 2'b10);

      // SUB to zero, then SUB with borrow
      issue(LDA, 8'h05);
      issue(LDB, 8'h05);
      issue(SUB, 8'h00);
      chk("sub_op", alu_op, 2'b01);
      wait_idle(busy);
      chk("sub0_a", alu_a, 8'h00);
      chk("sub0_flags", {carry_flag, zero_flag}, 2'b01);
      issue(LDA, 8'h03);
      chk("lda_flags_kept", {carry_flag, zero_flag}, 2'b01);
      issue(SUB, 8'h00);
      wait_idle(busy);
      chk("sub1_a", alu_a, 8'hFE);
      chk("sub1_flags", {carry_flag, zero_flag}, 2'b10);

      // Multi-step SHL; flags from the final step only
      issue(LDA, 8'h81);
      issue(SHL, 8'h03);
      chk("shl_op", alu_op, 2'b10);
      wait_idle(busy);
      chk("shl_busy", busy, 3);
      chk("shl_a", alu_a, 8'h08);
      chk("shl_flags", {carry_flag, zero_flag}, 2'b00);
      issue(SHR, 8'h00);
      chk("shr0_ready", cmd_ready, 1'b1);
      chk("shr0_a", alu_a, 8'h08);
      chk("shr0_flags", {carry_flag, zero_flag}, 2'b00);
      issue(NOP, 8'hAA);
      chk("nop_a", alu_a, 8'h08);
      chk("nop_ready", cmd_ready, 1'b1);

      // cmd_valid held high across EXEC: LDA waits for the EXEC edge
      issue(LDA, 8'h10);
      issue(LDB, 8'h01);
      cmd_valid = 1'b1; cmd_op = ADD; cmd_data = 8'h00;
      @(posedge clk); #1;
      cmd_op = LDA; cmd_data = 8'h33;
      chk("hold_busy", cmd_ready, 1'b0);
      @(posedge clk); #1;
      chk("hold_exec_a", alu_a, 8'h11);
      @(posedge clk); #1;
      cmd_valid = 1'b0; cmd_op = NOP;
      chk("hold_lda_a", alu_a, 8'h33);

      // Reset mid-SHIFT: immediate clear, first edge after release accepts
      issue(LDA, 8'hFF);
      issue(OUT, 8'h00);
      issue(SHR, 8'h07);
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("shr_mid_a", alu_a, 8'h3F);
      rst_n = 1'b0;
      #1;
      chk("arst_a", alu_a, 8'h00);
      chk("arst_b", alu_b, 8'h00);
      chk("arst_op", alu_op, 2'b00);
      chk("arst_flags", {carry_flag, zero_flag}, 2'b00);
      chk("arst_out", {out_valid, out_data}, 9'h000);
      chk("arst_ready", cmd_ready, 1'b1);
      #1 rst_n = 1'b1;
      issue(LDA, 8'h44);
      chk("post_rst_a", alu_a, 8'h44);

      // Back-to-back OUT
      issue(LDA, 8'h5A);
      issue(OUT, 8'h00);
      chk("out1", {out_valid, out_data}, 9'h15A);
      issue(OUT, 8'h00);
      chk("out2", {out_valid, out_data}, 9'h15A);
      @(posedge clk); #1;
      chk("out_end", {out_valid, out_data}, 9'h05A);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 8, meaning operand/result width (all 8-bit widths below are DATA_BITS).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, an asynchronous, active-low reset.
REQ-004 The block SHALL have port cmd_valid, input, 1, meaning a command is presented.
REQ-005 The block SHALL have port cmd_ready, output, 1, meaning a command can be accepted.
REQ-006 The block SHALL have port cmd_op, input, 3, carrying the command code: 000 LDA, 001 LDB, 010 ADD, 011 SUB, 100 SHL, 101 SHR, 110 OUT, 111 NOP.
REQ-007 The block SHALL have port cmd_data, input, 8, carrying load data (LDA/LDB) or the shift count in bits [2:0] (SHL/SHR).
REQ-008 The block SHALL have ports alu_a (output, 8), alu_b (output, 8) and alu_op (output, 2) driving the ALU operands and operation (00 add, 01 sub, 10 sll, 11 srl).
REQ-009 The block SHALL have ports alu_result (input, 8), alu_carry (input, 1) and alu_zero (input, 1), returned combinationally by the ALU.
REQ-010 The block SHALL have ports carry_flag (output, 1) and zero_flag (output, 1), the registered flags.
REQ-011 The block SHALL have ports out_valid (output, 1) and out_data (output, 8), the output port strobe and data.

Function
REQ-012 The block SHALL hold registers a_reg, b_reg, flags, a 3-bit shift counter and state in {IDLE, EXEC, SHIFT}; alu_a SHALL equal a_reg and alu_b SHALL equal b_reg at all times.
REQ-013 A command SHALL be accepted on a rising edge where cmd_valid=1 and cmd_ready=1; cmd_ready SHALL be 1 only in IDLE; in EXEC and SHIFT, cmd_valid SHALL be ignored and the requester holds cmd_op and cmd_data stable.
REQ-014 On acceptance, LDA/LDB SHALL load cmd_data into a_reg/b_reg on that edge, with state staying IDLE and flags unchanged.
REQ-015 ADD/SUB SHALL enter EXEC with alu_op 00/01; at the next edge a_reg<=alu_result, carry_flag<=alu_carry, zero_flag<=alu_zero, and state returns to IDLE; cmd_ready is low for exactly 1 cycle.
REQ-016 SUB carry SHALL be stored unmodified: it is the borrow, 1 iff a_reg<b_reg.
REQ-017 SHL/SHR with count N=cmd_data[2:0]>0 SHALL enter SHIFT with alu_op 10/11 and the counter set to N; each SHIFT edge SHALL write a_reg and both flags from the ALU and decrement the counter; when the counter reaches 0 the state SHALL return to IDLE; cmd_ready is low exactly N cycles.
REQ-018 After a multi-step shift, the flags SHALL reflect the final step only.
REQ-019 SHL/SHR with N=0 SHALL behave as NOP: no register or flag change and no busy cycle.
REQ-020 OUT SHALL set out_data<=a_reg and out_valid<=1 on the accepting edge; out_valid SHALL be 1 for exactly one cycle unless another OUT follows back-to-back; out_data SHALL hold its value until the next OUT.
REQ-021 NOP SHALL be accepted with no effect.
REQ-022 In IDLE, alu_op SHALL be driven as 00.
REQ-023 Back-to-back commands SHALL be accepted on consecutive edges in IDLE with no bubble for LDA, LDB, OUT and NOP.

Reset
REQ-024 While rst_n=0, the block SHALL force immediately, independent of clk: state IDLE, a_reg=0, b_reg=0, counter=0, carry_flag=0, zero_flag=0, out_valid=0, out_data=0, alu_op=00.
REQ-025 Reset asserted mid-EXEC or mid-SHIFT SHALL abort the operation without a partial writeback; no command SHALL be accepted while rst_n=0; the first acceptance SHALL be possible at the first rising edge after rst_n rises.

Verification
REQ-026 LDA 0xF0, LDB 0x20, ADD -> a_reg=0x10, carry_flag=1, zero_flag=0, and cmd_ready low for 1 cycle.
REQ-027 LDA 0x05, LDB 0x05, SUB -> a_reg=0x00, carry=0, zero=1; then LDA 0x03, SUB -> a_reg=0xFE, carry=1, zero=0.
REQ-028 LDA 0x81, SHL with cmd_data=0x03 -> a_reg=0x08, carry=0, zero=0 after exactly 3 busy cycles; SHR with cmd_data=0x00 -> no change and cmd_ready never drops.
REQ-029 cmd_valid held high with ADD then LDA -> LDA is accepted only on the edge after EXEC completes.
REQ-030 LDA 0xFF, SHR with cmd_data=0x07, rst_n pulsed low on the 3rd SHIFT cycle -> all outputs 0 immediately and cmd_ready=1 on the first edge after release.
REQ-031 LDA 0x5A, OUT, OUT -> out_valid high 2 cycles with out_data=0x5A, then out_valid low with out_data still 0x5A.
